// File: rtl/calc_mp_alu.sv
// calc_mp_alu: NPORTS request ports share one registered add/sub/shift ALU
// through a round-robin arbiter; each request yields exactly one tagged response.
`timescale 1ns/1ps
module calc_mp_alu #(
    parameter int unsigned NPORTS = 4,
    parameter int unsigned DW     = 32,
    parameter int unsigned SHW    = 5
) (
    input  logic                   c_clk,
    input  logic                   reset,
    input  logic [0:4*NPORTS-1]    req_cmd_in,
    input  logic [0:DW*NPORTS-1]   req_data_in,
    output logic [0:2*NPORTS-1]    out_resp,
    output logic [0:DW*NPORTS-1]   out_data,
    output logic [NPORTS-1:0]      busy
);

    localparam int unsigned PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RSP_NONE = 2'b00;
    localparam logic [1:0] RSP_OK   = 2'b01;
    localparam logic [1:0] RSP_OVF  = 2'b10;
    localparam logic [1:0] RSP_INV  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_OP2, S_PEND, S_WAIT_RSP} state_t;

    state_t            state_q [NPORTS];
    state_t            state_d [NPORTS];
    logic [3:0]        cmd_q   [NPORTS];
    logic [3:0]        cmd_d   [NPORTS];
    logic [DW-1:0]     op1_q   [NPORTS];
    logic [DW-1:0]     op1_d   [NPORTS];
    logic [DW-1:0]     op2_q   [NPORTS];
    logic [DW-1:0]     op2_d   [NPORTS];
    logic [1:0]        resp_q  [NPORTS];
    logic [1:0]        resp_d  [NPORTS];
    logic [DW-1:0]     data_q  [NPORTS];
    logic [DW-1:0]     data_d  [NPORTS];
    logic [NPORTS-1:0] busy_q;
    logic [NPORTS-1:0] busy_d;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     ptr_d;

    logic              gnt_vld;
    logic [PW-1:0]     gnt_idx;
    logic [1:0]        alu_resp;
    logic [DW-1:0]     alu_data;

    // State, operand, pointer and output registers
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < int'(NPORTS); p++) begin
                state_q[p] <= S_IDLE;
                cmd_q[p]   <= '0;
                op1_q[p]   <= '0;
                op2_q[p]   <= '0;
                resp_q[p]  <= RSP_NONE;
                data_q[p]  <= '0;
            end
            busy_q <= '0;
            ptr_q  <= '0;
        end else begin
            for (int p = 0; p < int'(NPORTS); p++) begin
                state_q[p] <= state_d[p];
                cmd_q[p]   <= cmd_d[p];
                op1_q[p]   <= op1_d[p];
                op2_q[p]   <= op2_d[p];
                resp_q[p]  <= resp_d[p];
                data_q[p]  <= data_d[p];
            end
            busy_q <= busy_d;
            ptr_q  <= ptr_d;
        end
    end

    // Round-robin arbiter: first PEND port at or after the pointer wins
    always_comb begin
        int unsigned cand;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            cand = (32'(ptr_q) + k) % NPORTS;
            if (!gnt_vld && state_q[PW'(cand)] == S_PEND) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(cand);
            end
        end
        ptr_d = ptr_q;
        if (gnt_vld) begin
            ptr_d = (32'(gnt_idx) == NPORTS - 1) ? '0 : PW'(32'(gnt_idx) + 1);
        end
    end

    // ALU evaluation of the granted port's operands
    always_comb begin
        logic [DW:0]   sum;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        a        = op1_q[gnt_idx];
        b        = op2_q[gnt_idx];
        sum      = {1'b0, a} + {1'b0, b};
        alu_resp = RSP_INV;
        alu_data = '0;
        case (cmd_q[gnt_idx])
            CMD_ADD: begin
                if (sum[DW]) begin
                    alu_resp = RSP_OVF;
                end else begin
                    alu_resp = RSP_OK;
                    alu_data = sum[DW-1:0];
                end
            end
            CMD_SUB: begin
                if (b > a) begin
                    alu_resp = RSP_OVF;
                end else begin
                    alu_resp = RSP_OK;
                    alu_data = a - b;
                end
            end
            CMD_SHL: begin
                alu_resp = RSP_OK;
                alu_data = a << b[SHW-1:0];
            end
            CMD_SHR: begin
                alu_resp = RSP_OK;
                alu_data = a >> b[SHW-1:0];
            end
            default: begin
                alu_resp = RSP_INV;
                alu_data = '0;
            end
        endcase
    end

    // Per-port next-state logic
    always_comb begin
        for (int p = 0; p < int'(NPORTS); p++) begin
            state_d[p] = state_q[p];
            case (state_q[p])
                S_IDLE:     if (req_cmd_in[4*p +: 4] != 4'd0) state_d[p] = S_OP2;
                S_OP2:      state_d[p] = S_PEND;
                S_PEND:     if (gnt_vld && gnt_idx == PW'(p)) state_d[p] = S_WAIT_RSP;
                S_WAIT_RSP: state_d[p] = S_IDLE;
                default:    state_d[p] = S_IDLE;
            endcase
        end
    end

    // Per-port operand capture, busy flag and response routing
    always_comb begin
        for (int p = 0; p < int'(NPORTS); p++) begin
            cmd_d[p]  = cmd_q[p];
            op1_d[p]  = op1_q[p];
            op2_d[p]  = op2_q[p];
            resp_d[p] = RSP_NONE;
            data_d[p] = '0;
            if (state_q[p] == S_IDLE && req_cmd_in[4*p +: 4] != 4'd0) begin
                cmd_d[p] = req_cmd_in[4*p +: 4];
                op1_d[p] = req_data_in[DW*p +: DW];
            end
            if (state_q[p] == S_OP2) begin
                op2_d[p] = req_data_in[DW*p +: DW];
            end
            if (gnt_vld && gnt_idx == PW'(p)) begin
                resp_d[p] = alu_resp;
                data_d[p] = alu_data;
            end
            busy_d[p] = (state_d[p] != S_IDLE);
        end
    end

    // Flatten per-port registers onto the output buses
    always_comb begin
        for (int p = 0; p < int'(NPORTS); p++) begin
            out_resp[2*p +: 2]   = resp_q[p];
            out_data[DW*p +: DW] = data_q[p];
        end
        busy = busy_q;
    end

endmodule

// File: tb/tb_calc_mp_alu.sv
// Directed, table-driven bench for calc_mp_alu (NPORTS=4, DW=32).
`timescale 1ns/1ps
module tb_calc_mp_alu;

    localparam int NP = 4;
    localparam int DW = 32;

    logic                c_clk;
    logic                reset;
    logic [0:4*NP-1]     req_cmd_in;
    logic [0:DW*NP-1]    req_data_in;
    logic [0:2*NP-1]     out_resp;
    logic [0:DW*NP-1]    out_data;
    logic [NP-1:0]       busy;

    int n_checks = 0;
    int n_fail   = 0;

    calc_mp_alu #(.NPORTS(NP), .DW(DW), .SHW(5)) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .busy        (busy)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    typedef struct {
        int          port;
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  resp;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [14];

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [3:0] c, input logic [31:0] d);
        req_cmd_in[4*p +: 4]   = c;
        req_data_in[DW*p +: DW] = d;
    endtask

    // One uncontended request: op1 cycle, op2 cycle, response two cycles after op2
    task automatic run_op(input string name, input int p, input logic [3:0] c,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] er, input logic [31:0] ed);
        logic [0:2*NP-1] exp_resp;
        set_port(p, c, a);
        tick();
        set_port(p, 4'd0, b);
        tick();
        set_port(p, 4'd0, 32'd0);
        check({name, "_pend_noresp"}, 64'(out_resp), 64'd0);
        tick();
        exp_resp = '0;
        exp_resp[2*p +: 2] = er;
        check({name, "_resp"}, 64'(out_resp), 64'(exp_resp));
        check({name, "_data"}, 64'(out_data[DW*p +: DW]), 64'(ed));
        tick();
        check({name, "_after_resp"}, 64'(out_resp), 64'd0);
        check({name, "_busy_clear"}, 64'(busy), 64'd0);
    endtask

    // All ports request together; responses must come out in order 0..NP-1
    task automatic contention(input string name, input int base);
        logic [0:2*NP-1] exp_resp;
        for (int p = 0; p < NP; p++) set_port(p, 4'd1, 32'(base * (p + 1)));
        tick();
        for (int p = 0; p < NP; p++) set_port(p, 4'd0, 32'(p));
        tick();
        for (int p = 0; p < NP; p++) set_port(p, 4'd0, 32'd0);
        check({name, "_all_busy"}, 64'(busy), 64'hF);
        for (int c = 0; c < NP; c++) begin
            tick();
            exp_resp = '0;
            exp_resp[2*c +: 2] = 2'b01;
            check($sformatf("%s_resp_c%0d", name, c), 64'(out_resp), 64'(exp_resp));
            check($sformatf("%s_data_c%0d", name, c), 64'(out_data[DW*c +: DW]),
                  64'(base * (c + 1) + c));
        end
        tick();
        check({name, "_idle"}, 64'(busy), 64'd0);
        check({name, "_quiet"}, 64'(out_resp), 64'd0);
    endtask

    initial begin
        reset       = 1'b1;
        req_cmd_in  = '0;
        req_data_in = '0;

        vecs[0]  = '{0, 4'd1, 32'd5,          32'd7,  2'b01, 32'd12};
        vecs[1]  = '{3, 4'd1, 32'hFFFF_FFFF,  32'd1,  2'b10, 32'd0};
        vecs[2]  = '{0, 4'd1, 32'hFFFF_FFFE,  32'd1,  2'b01, 32'hFFFF_FFFF};
        vecs[3]  = '{1, 4'd2, 32'd3,          32'd5,  2'b10, 32'd0};
        vecs[4]  = '{1, 4'd2, 32'd9,          32'd9,  2'b01, 32'd0};
        vecs[5]  = '{2, 4'd2, 32'd10,         32'd3,  2'b01, 32'd7};
        vecs[6]  = '{0, 4'd5, 32'd1,          32'd31, 2'b01, 32'h8000_0000};
        vecs[7]  = '{0, 4'd5, 32'd1,          32'd33, 2'b01, 32'd2};
        vecs[8]  = '{3, 4'd6, 32'h8000_0000,  32'd31, 2'b01, 32'd1};
        vecs[9]  = '{3, 4'd6, 32'hFFFF_FFFF,  32'd36, 2'b01, 32'h0FFF_FFFF};
        vecs[10] = '{2, 4'd3, 32'd1,          32'd1,  2'b11, 32'd0};
        vecs[11] = '{2, 4'd4, 32'd8,          32'd8,  2'b11, 32'd0};
        vecs[12] = '{1, 4'd15, 32'd8,         32'd8,  2'b11, 32'd0};
        vecs[13] = '{1, 4'd7, 32'd0,          32'd0,  2'b11, 32'd0};

        tick();
        tick();
        check("reset_resp", 64'(out_resp), 64'd0);
        check("reset_data", 64'(out_data), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick();
        check("post_reset_busy", 64'(busy), 64'd0);

        // Contention with the pointer at 0, then again right after it wraps
        contention("cont1", 100);
        contention("cont2", 1000);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].port, vecs[i].cmd,
                   vecs[i].op1, vecs[i].op2, vecs[i].resp, vecs[i].data);
        end

        for (int i = 0; i < DW; i++) begin
            run_op($sformatf("walk%0d", i), 1, 4'd1, 32'd1 << i, 32'd0,
                   2'b01, 32'd1 << i);
        end

        // Reset during the op2 cycle on port 2 discards the request
        set_port(2, 4'd1, 32'd1);
        tick();
        set_port(2, 4'd0, 32'd1);
        check("midop_busy_before", 64'(busy[2]), 64'd1);
        reset = 1'b1;
        #1;
        check("midop_busy_async", 64'(busy), 64'd0);
        tick();
        set_port(2, 4'd0, 32'd0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("midop_noresp%0d", c), 64'(out_resp), 64'd0);
            check($sformatf("midop_idle%0d", c), 64'(busy), 64'd0);
            tick();
        end
        run_op("after_reset", 2, 4'd1, 32'd2, 32'd2, 2'b01, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
